load_store_unit: RTL and testbench
==================================

LOAD_STORE_UNIT -- requirements
Module: load_store_unit

Interface
REQ-001 SHALL have parameter WORD_SIZE, default 32: data and address width.
REQ-002 SHALL have parameter MEM_SIZE, default 1024: bytes in the downstream byte memory.
REQ-003 SHALL have port clk_i, input, 1: single clock; all state changes on its rising edge.
REQ-004 SHALL have port rst_i, input, 1: reset, asynchronous and active-high.
REQ-005 SHALL have ports req_valid_i (in, 1) and req_ready_o (out, 1): request handshake.
REQ-006 SHALL have ports req_we_i (in, 1), req_size_i (in, 2; 00 byte, 01 half, 10 word, 11 reserved) and req_unsigned_i (in, 1).
REQ-007 SHALL have ports req_base_i, req_offset_i and req_wdata_i, each input, WORD_SIZE wide.
REQ-008 SHALL have ports resp_valid_o (out, 1), resp_data_o (out, WORD_SIZE) and resp_err_o (out, 1).
REQ-009 SHALL have memory-side ports en_mem_o, mem_read_o and mem_write_o (out, 1 each); addr_base_o, addr_offset_o and mem_wdata_o (out, WORD_SIZE each); and mem_rdata_i (in, WORD_SIZE).

Function
REQ-010 SHALL use FSM states IDLE, RD_SETUP, RD_STROBE, RD_CAPTURE, WR_SETUP, WR_STROBE and RESP.
REQ-011 SHALL assert req_ready_o only in IDLE with rst_i low, and latch all req_* fields when req_valid_i and req_ready_o are both high.
REQ-012 SHALL compute the effective address as req_base_i + req_offset_i modulo 2^WORD_SIZE.
REQ-013 SHALL skip the memory access and go straight to RESP with resp_err_o=1 when req_size_i=11 or the effective address + 3 exceeds MEM_SIZE-1.
REQ-014 SHALL route accepted loads and byte/half stores to RD_SETUP, and word stores to WR_SETUP.
REQ-015 SHALL make the transitions RD_SETUP->RD_STROBE->RD_CAPTURE and WR_SETUP->WR_STROBE->RESP, each taking one cycle.
REQ-016 SHALL, in RD_CAPTURE, register mem_rdata_i, then go to RESP for a load or to WR_SETUP for a partial store.
REQ-017 SHALL drive all memory-side outputs from registers, so en_mem_o is glitch-free.
REQ-018 SHALL hold en_mem_o high only in the STROBE states, and keep address, read/write and mem_wdata_o stable from SETUP through the cycle after STROBE.
REQ-019 SHALL never assert mem_read_o and mem_write_o together.
REQ-020 SHALL drive addr_base_o and addr_offset_o with the latched base and offset unchanged.
REQ-021 SHALL, for a partial store, replace bits [7:0] (byte) or [15:0] (half) of the read word with req_wdata_i and write the full word back to the same address.
REQ-022 SHALL return load data as bits [7:0] or [15:0] of the read word, sign-extended, or zero-extended when req_unsigned_i=1; a word load returns the word unchanged.
REQ-023 SHALL pulse resp_valid_o for exactly one cycle in RESP, then return to IDLE.
REQ-024 SHALL hold resp_data_o and resp_err_o until the next RESP.
REQ-025 SHALL return resp_data_o=0 for stores and errors.
REQ-026 SHALL meet these latencies from the accept edge to resp_valid_o: load 4 cycles, word store 3, partial store 6, error 1.
REQ-027 SHALL ignore req_valid_i outside IDLE; back-to-back requests are accepted in the IDLE cycle that follows RESP.

Reset
REQ-028 SHALL, while rst_i is high, force state=IDLE; en_mem_o, mem_read_o, mem_write_o, resp_valid_o, resp_err_o and req_ready_o=0; and addr_base_o, addr_offset_o, mem_wdata_o and resp_data_o=0.
REQ-029 SHALL, on reset mid-operation, abort with no response; a write strobe already issued is not undone.

Configuration
REQ-030 SHALL, with LSU_MISALIGN_TRAP_EN defined, treat a half access at an odd address or a word access at an address not a multiple of 4 as an error (REQ-013 path).
REQ-031 SHALL, without LSU_MISALIGN_TRAP_EN, perform all alignments normally.

Structure
REQ-032 SHALL place the size encodings, the FSM state enum and the latency constants in package lsu_pkg.
REQ-033 SHALL put byte-lane merge and load extension in one combinational sub-module, lsu_lane_unit.

Verification
REQ-034 SHALL verify: word store 0xDEADBEEF at base 0x10, offset 0x4, then word load at 0x14 -> resp_data_o=0xDEADBEEF, store latency 3, load latency 4.
REQ-035 SHALL verify: byte store 0x80 at 0x14, then signed byte load -> 0xFFFFFF80; unsigned byte load -> 0x00000080; word load -> 0xDEADBE80.
REQ-036 SHALL verify: half load at effective address 1022 with MEM_SIZE=1024 -> resp_err_o=1 after 1 cycle, en_mem_o never high.
REQ-037 SHALL verify: rst_i asserted during RD_STROBE -> en_mem_o=0 immediately, no resp_valid_o, req_ready_o=1 the cycle after release.
REQ-038 SHALL verify: half load at 0x21 -> resp_err_o=1 with LSU_MISALIGN_TRAP_EN defined, and valid data without it.
REQ-039 SHALL verify: req_valid_i held high continuously -> exactly one accept per IDLE, and mem_read_o and mem_write_o never both high.

Source files
------------

// File: rtl/lsu_pkg.sv
// Shared encodings for the load/store unit: access sizes, FSM states and
// the accept-to-response latencies of each request class.
package lsu_pkg;

  typedef enum logic [1:0] {
    SZ_BYTE = 2'b00,
    SZ_HALF = 2'b01,
    SZ_WORD = 2'b10,
    SZ_RSVD = 2'b11
  } lsu_size_e;

  typedef enum logic [2:0] {
    IDLE,
    RD_SETUP,
    RD_STROBE,
    RD_CAPTURE,
    WR_SETUP,
    WR_STROBE,
    RESP
  } lsu_state_e;

  localparam int LAT_LOAD       = 4;
  localparam int LAT_WORD_STORE = 3;
  localparam int LAT_PART_STORE = 6;
  localparam int LAT_ERR        = 1;

endpackage

// File: rtl/lsu_lane_unit.sv
// Byte-lane datapath: merges store data into a read word for partial stores
// and sign/zero-extends narrow load data.
module lsu_lane_unit
  import lsu_pkg::*;
#(
  parameter int WORD_SIZE = 32
) (
  input  logic [WORD_SIZE-1:0] rdata_i,
  input  logic [WORD_SIZE-1:0] wdata_i,
  input  lsu_size_e            size_i,
  input  logic                 unsigned_i,
  output logic [WORD_SIZE-1:0] merged_o,
  output logic [WORD_SIZE-1:0] load_o
);

  always_comb begin
    merged_o = wdata_i;
    load_o   = rdata_i;
    case (size_i)
      SZ_BYTE: begin
        merged_o = {rdata_i[WORD_SIZE-1:8], wdata_i[7:0]};
        load_o   = {{(WORD_SIZE-8){~unsigned_i & rdata_i[7]}}, rdata_i[7:0]};
      end
      SZ_HALF: begin
        merged_o = {rdata_i[WORD_SIZE-1:16], wdata_i[15:0]};
        load_o   = {{(WORD_SIZE-16){~unsigned_i & rdata_i[15]}}, rdata_i[15:0]};
      end
      default: begin
        merged_o = wdata_i;
        load_o   = rdata_i;
      end
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// Load/store unit driving a byte memory through a setup/strobe/capture FSM.
// Define LSU_MISALIGN_TRAP_EN to report misaligned half/word accesses as errors.
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int WORD_SIZE = 32,
  parameter int MEM_SIZE  = 1024
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 req_valid_i,
  output logic                 req_ready_o,
  input  logic                 req_we_i,
  input  logic [1:0]           req_size_i,
  input  logic                 req_unsigned_i,
  input  logic [WORD_SIZE-1:0] req_base_i,
  input  logic [WORD_SIZE-1:0] req_offset_i,
  input  logic [WORD_SIZE-1:0] req_wdata_i,
  output logic                 resp_valid_o,
  output logic [WORD_SIZE-1:0] resp_data_o,
  output logic                 resp_err_o,
  output logic                 en_mem_o,
  output logic                 mem_read_o,
  output logic                 mem_write_o,
  output logic [WORD_SIZE-1:0] addr_base_o,
  output logic [WORD_SIZE-1:0] addr_offset_o,
  output logic [WORD_SIZE-1:0] mem_wdata_o,
  input  logic [WORD_SIZE-1:0] mem_rdata_i
);

  // A request is accepted when req_valid_i and req_ready_o are high at a rising edge.
  lsu_state_e           state_q, state_d;
  logic                 we_q, we_d, uns_q, uns_d;
  lsu_size_e            size_q, size_d;
  logic [WORD_SIZE-1:0] base_q, base_d, off_q, off_d, wdata_q, wdata_d;
  logic                 en_q, en_d, rd_q, rd_d, wr_q, wr_d;
  logic [WORD_SIZE-1:0] mem_wdata_q, mem_wdata_d;
  logic                 resp_valid_q, resp_valid_d, resp_err_q, resp_err_d;
  logic [WORD_SIZE-1:0] resp_data_q, resp_data_d;

  lsu_size_e            req_size;
  logic [WORD_SIZE-1:0] eff_addr;
  logic [WORD_SIZE:0]   last_byte;
  logic                 req_err;
  logic [WORD_SIZE-1:0] merged, load_data;

  lsu_lane_unit #(.WORD_SIZE(WORD_SIZE)) u_lane (
    .rdata_i    (mem_rdata_i),
    .wdata_i    (wdata_q),
    .size_i     (size_q),
    .unsigned_i (uns_q),
    .merged_o   (merged),
    .load_o     (load_data)
  );

  // The memory is always accessed as a full word, so all four bytes must fit.
  always_comb begin
    req_size  = lsu_size_e'(req_size_i);
    eff_addr  = req_base_i + req_offset_i;
    last_byte = {1'b0, eff_addr} + (WORD_SIZE+1)'(3);
    req_err   = (req_size == SZ_RSVD) || (last_byte > (WORD_SIZE+1)'(MEM_SIZE-1));
`ifdef LSU_MISALIGN_TRAP_EN
    if ((req_size == SZ_HALF) && eff_addr[0]) req_err = 1'b1;
    if ((req_size == SZ_WORD) && (eff_addr[1:0] != 2'b00)) req_err = 1'b1;
`else
    req_err = req_err;
`endif
  end

  always_comb begin
    state_d      = state_q;
    we_d         = we_q;
    size_d       = size_q;
    uns_d        = uns_q;
    base_d       = base_q;
    off_d        = off_q;
    wdata_d      = wdata_q;
    en_d         = 1'b0;
    rd_d         = rd_q;
    wr_d         = wr_q;
    mem_wdata_d  = mem_wdata_q;
    resp_valid_d = 1'b0;
    resp_err_d   = resp_err_q;
    resp_data_d  = resp_data_q;
    case (state_q)
      IDLE: begin
        if (req_valid_i) begin
          we_d    = req_we_i;
          size_d  = req_size;
          uns_d   = req_unsigned_i;
          base_d  = req_base_i;
          off_d   = req_offset_i;
          wdata_d = req_wdata_i;
          if (req_err) begin
            state_d      = RESP;
            resp_valid_d = 1'b1;
            resp_err_d   = 1'b1;
            resp_data_d  = '0;
          end else if (req_we_i && (req_size == SZ_WORD)) begin
            state_d     = WR_SETUP;
            wr_d        = 1'b1;
            rd_d        = 1'b0;
            mem_wdata_d = req_wdata_i;
          end else begin
            state_d = RD_SETUP;
            rd_d    = 1'b1;
            wr_d    = 1'b0;
          end
        end
      end
      RD_SETUP: begin
        state_d = RD_STROBE;
        en_d    = 1'b1;
      end
      RD_STROBE: state_d = RD_CAPTURE;
      RD_CAPTURE: begin
        rd_d = 1'b0;
        if (we_q) begin
          state_d     = WR_SETUP;
          wr_d        = 1'b1;
          mem_wdata_d = merged;
        end else begin
          state_d      = RESP;
          resp_valid_d = 1'b1;
          resp_err_d   = 1'b0;
          resp_data_d  = load_data;
        end
      end
      WR_SETUP: begin
        state_d = WR_STROBE;
        en_d    = 1'b1;
      end
      WR_STROBE: begin
        state_d      = RESP;
        resp_valid_d = 1'b1;
        resp_err_d   = 1'b0;
        resp_data_d  = '0;
      end
      RESP: begin
        state_d = IDLE;
        wr_d    = 1'b0;
        rd_d    = 1'b0;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q      <= IDLE;
      we_q         <= 1'b0;
      size_q       <= SZ_BYTE;
      uns_q        <= 1'b0;
      base_q       <= '0;
      off_q        <= '0;
      wdata_q      <= '0;
      en_q         <= 1'b0;
      rd_q         <= 1'b0;
      wr_q         <= 1'b0;
      mem_wdata_q  <= '0;
      resp_valid_q <= 1'b0;
      resp_err_q   <= 1'b0;
      resp_data_q  <= '0;
    end else begin
      state_q      <= state_d;
      we_q         <= we_d;
      size_q       <= size_d;
      uns_q        <= uns_d;
      base_q       <= base_d;
      off_q        <= off_d;
      wdata_q      <= wdata_d;
      en_q         <= en_d;
      rd_q         <= rd_d;
      wr_q         <= wr_d;
      mem_wdata_q  <= mem_wdata_d;
      resp_valid_q <= resp_valid_d;
      resp_err_q   <= resp_err_d;
      resp_data_q  <= resp_data_d;
    end
  end

  assign req_ready_o   = (state_q == IDLE) && !rst_i;
  assign en_mem_o      = en_q;
  assign mem_read_o    = rd_q;
  assign mem_write_o   = wr_q;
  assign addr_base_o   = base_q;
  assign addr_offset_o = off_q;
  assign mem_wdata_o   = mem_wdata_q;
  assign resp_valid_o  = resp_valid_q;
  assign resp_err_o    = resp_err_q;
  assign resp_data_o   = resp_data_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Scoreboard bench for load_store_unit: directed requests push expected
// responses; a negedge monitor pops and compares each resp_valid_o pulse.
module tb_load_store_unit;

  logic        clk_i = 1'b0;
  logic        rst_i = 1'b1;
  logic        req_valid_i = 1'b0;
  logic        req_ready_o;
  logic        req_we_i = 1'b0;
  logic [1:0]  req_size_i = 2'b00;
  logic        req_unsigned_i = 1'b0;
  logic [31:0] req_base_i = '0, req_offset_i = '0, req_wdata_i = '0;
  logic        resp_valid_o, resp_err_o;
  logic [31:0] resp_data_o;
  logic        en_mem_o, mem_read_o, mem_write_o;
  logic [31:0] addr_base_o, addr_offset_o, mem_wdata_o;
  logic [31:0] mem_rdata_i = '0;

  load_store_unit #(.WORD_SIZE(32), .MEM_SIZE(1024)) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .req_valid_i(req_valid_i), .req_ready_o(req_ready_o),
    .req_we_i(req_we_i), .req_size_i(req_size_i), .req_unsigned_i(req_unsigned_i),
    .req_base_i(req_base_i), .req_offset_i(req_offset_i), .req_wdata_i(req_wdata_i),
    .resp_valid_o(resp_valid_o), .resp_data_o(resp_data_o), .resp_err_o(resp_err_o),
    .en_mem_o(en_mem_o), .mem_read_o(mem_read_o), .mem_write_o(mem_write_o),
    .addr_base_o(addr_base_o), .addr_offset_o(addr_offset_o),
    .mem_wdata_o(mem_wdata_o), .mem_rdata_i(mem_rdata_i)
  );

  // ---------------- clock / reset ----------------
  always #5 clk_i = ~clk_i;

  int cyc = 0;
  initial forever @(posedge clk_i) cyc++;

  // ---------------- byte memory model (little-endian) ----------------
  logic [7:0] mem [0:1023];
  logic [31:0] mem_addr;
  assign mem_addr = addr_base_o + addr_offset_o;

  always @(posedge clk_i) begin
    if (en_mem_o && mem_read_o)
      mem_rdata_i <= {mem[mem_addr[9:0]+10'd3], mem[mem_addr[9:0]+10'd2],
                      mem[mem_addr[9:0]+10'd1], mem[mem_addr[9:0]]};
    if (en_mem_o && mem_write_o) begin
      mem[mem_addr[9:0]]       <= mem_wdata_o[7:0];
      mem[mem_addr[9:0]+10'd1] <= mem_wdata_o[15:8];
      mem[mem_addr[9:0]+10'd2] <= mem_wdata_o[23:16];
      mem[mem_addr[9:0]+10'd3] <= mem_wdata_o[31:24];
    end
  end

  // ---------------- scoreboard ----------------
  logic [64:0] exp_q[$];  // {err, data, cycle at which resp_valid_o is seen}
  int checks = 0;
  int errors = 0;
  int issued = 0;
  int acc_cnt = 0;
  int en_cnt = 0;
  int rw_both = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // ---------------- monitor ----------------
  logic ready_prev = 1'b0;
  initial forever begin
    @(negedge clk_i);
    if (mem_read_o && mem_write_o) rw_both++;
    if (en_mem_o) en_cnt++;
    if (ready_prev && !req_ready_o && !rst_i) acc_cnt++;
    ready_prev = req_ready_o;
    if (resp_valid_o) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_resp actual=resp_valid required=none");
      end else begin
        logic [64:0] e;
        e = exp_q.pop_front();
        check("resp_err", 64'(resp_err_o), 64'(e[64]));
        check("resp_data", 64'(resp_data_o), 64'(e[63:32]));
        check("resp_cycle", 64'(cyc), 64'(e[31:0]));
      end
    end
  end

  // ---------------- driver ----------------
  // lat counts the accept edge as cycle 1.
  task automatic issue(input logic we, input logic [1:0] sz, input logic uns,
                       input logic [31:0] base, input logic [31:0] off, input logic [31:0] wd,
                       input logic exp_err, input logic [31:0] exp_data, input int lat,
                       input logic hold, input logic expect_resp);
    int n;
    @(negedge clk_i);
    req_we_i = we; req_size_i = sz; req_unsigned_i = uns;
    req_base_i = base; req_offset_i = off; req_wdata_i = wd;
    req_valid_i = 1'b1;
    n = 0;
    while (!req_ready_o && n < 50) begin
      @(negedge clk_i);
      n++;
    end
    if (n >= 50) begin
      checks++;
      errors++;
      $display("FAIL accept_timeout actual=no_ready required=ready");
      req_valid_i = 1'b0;
    end else begin
      issued++;
      if (expect_resp) exp_q.push_back({exp_err, exp_data, 32'(cyc + lat)});
      @(posedge clk_i);
      if (!hold) begin
        #1 req_valid_i = 1'b0;
      end
    end
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 50) begin
      @(negedge clk_i);
      n++;
    end
    if (exp_q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL resp_timeout actual=%0d_pending required=0", exp_q.size());
      exp_q.delete();
    end
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    int en0;
    int n;
    #12;
    check("rst_ready", 64'(req_ready_o), 64'(0));
    check("rst_en", 64'(en_mem_o), 64'(0));
    check("rst_rw", 64'({mem_read_o, mem_write_o}), 64'(0));
    check("rst_resp", 64'({resp_valid_o, resp_err_o}), 64'(0));
    check("rst_data", 64'(resp_data_o), 64'(0));
    check("rst_addr", {addr_base_o, addr_offset_o}, 64'(0));
    check("rst_wdata", 64'(mem_wdata_o), 64'(0));
    @(negedge clk_i);
    rst_i = 1'b0;

    // word store / load round trip
    issue(1, 2'b10, 0, 32'h10, 32'h4, 32'hDEADBEEF, 0, 32'h0, 3, 0, 1);
    issue(0, 2'b10, 0, 32'h14, 32'h0, 32'h0, 0, 32'hDEADBEEF, 4, 0, 1);
    // byte store then loads
    issue(1, 2'b00, 0, 32'h10, 32'h4, 32'h00000080, 0, 32'h0, 6, 0, 1);
    issue(0, 2'b00, 0, 32'h14, 32'h0, 32'h0, 0, 32'hFFFFFF80, 4, 0, 1);
    issue(0, 2'b00, 1, 32'h14, 32'h0, 32'h0, 0, 32'h00000080, 4, 0, 1);
    issue(0, 2'b10, 0, 32'h14, 32'h0, 32'h0, 0, 32'hDEADBE80, 4, 0, 1);
    drain();
    repeat (3) @(negedge clk_i);
    check("resp_data_hold", 64'(resp_data_o), 64'h00000000DEADBE80);

    // out-of-range and reserved-size errors never touch memory
    en0 = en_cnt;
    issue(0, 2'b01, 0, 32'h3F0, 32'hE, 32'h0, 1, 32'h0, 1, 0, 1);
    issue(0, 2'b11, 0, 32'h10, 32'h0, 32'h0, 1, 32'h0, 1, 0, 1);
    issue(0, 2'b00, 0, 32'h3FD, 32'h0, 32'h0, 1, 32'h0, 1, 0, 1);
    drain();
    check("err_no_strobe", 64'(en_cnt), 64'(en0));

    // top-of-memory word and address wraparound
    issue(1, 2'b10, 0, 32'h3FC, 32'h0, 32'h0BADF00D, 0, 32'h0, 3, 0, 1);
    issue(0, 2'b10, 0, 32'h3FC, 32'h0, 32'h0, 0, 32'h0BADF00D, 4, 0, 1);
    issue(1, 2'b10, 0, 32'hFFFFFFF8, 32'hC, 32'h12345678, 0, 32'h0, 3, 0, 1);
    issue(0, 2'b10, 0, 32'h4, 32'h0, 32'h0, 0, 32'h12345678, 4, 0, 1);

    // misaligned half load and half store merge
    issue(1, 2'b10, 0, 32'h20, 32'h0, 32'h11223344, 0, 32'h0, 3, 0, 1);
    issue(1, 2'b10, 0, 32'h20, 32'h4, 32'h55667788, 0, 32'h0, 3, 0, 1);
`ifdef LSU_MISALIGN_TRAP_EN
    issue(0, 2'b01, 0, 32'h21, 32'h0, 32'h0, 1, 32'h0, 1, 0, 1);
`else
    issue(0, 2'b01, 0, 32'h21, 32'h0, 32'h0, 0, 32'h00002233, 4, 0, 1);
`endif
    issue(1, 2'b01, 0, 32'h20, 32'h2, 32'hFFFF8001, 0, 32'h0, 6, 0, 1);
    issue(0, 2'b01, 0, 32'h22, 32'h0, 32'h0, 0, 32'hFFFF8001, 4, 0, 1);
    issue(0, 2'b01, 1, 32'h22, 32'h0, 32'h0, 0, 32'h00008001, 4, 0, 1);
    issue(0, 2'b10, 0, 32'h20, 32'h0, 32'h0, 0, 32'h80013344, 4, 0, 1);

    // req_valid_i held high across back-to-back requests
    issue(0, 2'b10, 0, 32'h14, 32'h0, 32'h0, 0, 32'hDEADBE80, 4, 1, 1);
    issue(1, 2'b10, 0, 32'h30, 32'h0, 32'hCAFEF00D, 0, 32'h0, 3, 1, 1);
    issue(0, 2'b10, 0, 32'h30, 32'h0, 32'h0, 0, 32'hCAFEF00D, 4, 0, 1);
    drain();

    // reset during RD_STROBE aborts with no response
    issue(0, 2'b10, 0, 32'h14, 32'h0, 32'h0, 0, 32'h0, 4, 0, 0);
    n = 0;
    while (!en_mem_o && n < 10) begin
      @(negedge clk_i);
      n++;
    end
    check("strobe_before_rst", 64'(en_mem_o), 64'(1));
    rst_i = 1'b1;
    #1;
    check("rst_mid_en", 64'(en_mem_o), 64'(0));
    check("rst_mid_rw", 64'({mem_read_o, mem_write_o}), 64'(0));
    check("rst_mid_ready", 64'(req_ready_o), 64'(0));
    repeat (2) @(negedge clk_i);
    rst_i = 1'b0;
    @(negedge clk_i);
    check("ready_after_rst", 64'(req_ready_o), 64'(1));
    repeat (6) @(negedge clk_i);

    check("accept_count", 64'(acc_cnt), 64'(issued));
    check("rd_wr_exclusive", 64'(rw_both), 64'(0));
    check("queue_empty", 64'(exp_q.size()), 64'(0));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
